gpr_bus_master: RTL and testbench

Bus initiator for the general purpose register file: accepts register read, read-pair and write requests from the CPU control path and sequences them onto the register file's single address/data/rd/wr port. It accounts for the register file's one-cycle registered read and overlaps the two reads of a pair. It sits between the instruction sequencer (operand fetch / writeback) and the register file.

---
 rtl/gpr_bus_master_if.sv | 37 +++
 rtl/gpr_bus_master.sv | 133 +++++++++++++
 tb/tb_gpr_bus_master.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpr_bus_master_if.sv
// Request/response handshake and register-file bus bundle for gpr_bus_master.
// The master modport is the sequencer's view; slave is the CPU + register file side.
interface gpr_bus_master_if #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 12
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [3:0]        req_addr_a;
    logic [3:0]        req_addr_b;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_data_a;
    logic [DATA_W-1:0] rsp_data_b;

    logic [ADDR_W-1:0] bus_addr;
    logic              bus_rd;
    logic              bus_wr;
    logic [DATA_W-1:0] bus_dout;
    logic              bus_oe;
    logic [DATA_W-1:0] bus_din;

    modport master (
        input  req_valid, req_op, req_addr_a, req_addr_b, req_wdata, bus_din,
        output req_ready, rsp_valid, rsp_err, rsp_data_a, rsp_data_b,
               bus_addr, bus_rd, bus_wr, bus_dout, bus_oe
    );

    modport slave (
        output req_valid, req_op, req_addr_a, req_addr_b, req_wdata, bus_din,
        input  req_ready, rsp_valid, rsp_err, rsp_data_a, rsp_data_b,
               bus_addr, bus_rd, bus_wr, bus_dout, bus_oe
    );
endinterface

// File: rtl/gpr_bus_master.sv
// Sequences register read, read-pair and write requests onto the register file's
// single port, accounting for its one-cycle registered read data.
module gpr_bus_master #(
    parameter int DATA_W = 14,
    parameter int ADDR_W = 12
) (
    input  logic               clk,
    input  logic               rst,
    gpr_bus_master_if.master   bif
);

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        CAP_B,
        CAP_A,
        WR,
        RESP
    } state_t;

    state_t     state;
    logic       pair_q;
    logic [3:0] addr_b_q;

    function automatic logic [ADDR_W-1:0] zext(input logic [3:0] idx);
        return {{(ADDR_W-4){1'b0}}, idx};
    endfunction

    // Every output is registered and set on the edge entering the state it
    // belongs to; the defaults below return the bus to all-zero between strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            pair_q         <= 1'b0;
            addr_b_q       <= '0;
            bif.req_ready  <= 1'b1;
            bif.rsp_valid  <= 1'b0;
            bif.rsp_err    <= 1'b0;
            bif.rsp_data_a <= '0;
            bif.rsp_data_b <= '0;
            bif.bus_addr   <= '0;
            bif.bus_rd     <= 1'b0;
            bif.bus_wr     <= 1'b0;
            bif.bus_dout   <= '0;
            bif.bus_oe     <= 1'b0;
        end else begin
            bif.req_ready <= 1'b0;
            bif.rsp_valid <= 1'b0;
            bif.rsp_err   <= 1'b0;
            bif.bus_addr  <= '0;
            bif.bus_rd    <= 1'b0;
            bif.bus_wr    <= 1'b0;
            bif.bus_dout  <= '0;
            bif.bus_oe    <= 1'b0;

            case (state)
                IDLE: begin
                    bif.req_ready <= 1'b1;
                    if (bif.req_valid && bif.req_ready) begin
                        bif.req_ready <= 1'b0;
                        pair_q        <= (bif.req_op == 2'b10);
                        addr_b_q      <= bif.req_addr_b;
                        case (bif.req_op)
                            2'b00, 2'b10: begin
                                state        <= RD_A;
                                bif.bus_rd   <= 1'b1;
                                bif.bus_addr <= zext(bif.req_addr_a);
                            end
                            2'b01: begin
                                state        <= WR;
                                bif.bus_wr   <= 1'b1;
                                bif.bus_oe   <= 1'b1;
                                bif.bus_addr <= zext(bif.req_addr_a);
                                bif.bus_dout <= bif.req_wdata;
                            end
                            default: begin
                                state         <= RESP;
                                bif.rsp_valid <= 1'b1;
                                bif.rsp_err   <= 1'b1;
                            end
                        endcase
                    end
                end

                // The B strobe is issued while A's data is still in flight, so
                // the pair costs one cycle more than a single read.
                RD_A: begin
                    if (pair_q) begin
                        state        <= RD_B;
                        bif.bus_rd   <= 1'b1;
                        bif.bus_addr <= zext(addr_b_q);
                    end else begin
                        state <= CAP_A;
                    end
                end

                RD_B: begin
                    bif.rsp_data_a <= bif.bus_din;
                    state          <= CAP_B;
                end

                CAP_B: begin
                    bif.rsp_data_b <= bif.bus_din;
                    bif.rsp_valid  <= 1'b1;
                    state          <= RESP;
                end

                CAP_A: begin
                    bif.rsp_data_a <= bif.bus_din;
                    bif.rsp_valid  <= 1'b1;
                    state          <= RESP;
                end

                WR: begin
                    bif.rsp_valid <= 1'b1;
                    state         <= RESP;
                end

                RESP: begin
                    bif.req_ready <= 1'b1;
                    state         <= IDLE;
                end

                default: begin
                    bif.req_ready <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gpr_bus_master.sv
// Scoreboard bench for gpr_bus_master: directed requests push expected responses,
// a forked monitor pops and compares them and logs bus strobes.
module tb_gpr_bus_master;
    localparam int DATA_W = 14;
    localparam int ADDR_W = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gpr_bus_master_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bif ();

    gpr_bus_master #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bif (bif)
    );

    // Register file model: write on the edge ending WR, registered read data.
    logic [DATA_W-1:0] regs [16];
    logic [DATA_W-1:0] rf_q;
    logic [DATA_W-1:0] rand_din;
    logic              use_rand;

    always @(posedge clk) begin
        if (bif.bus_wr) regs[bif.bus_addr[3:0]] <= bif.bus_dout;
        if (bif.bus_rd) rf_q <= regs[bif.bus_addr[3:0]];
    end

    always @(negedge clk) rand_din <= DATA_W'($urandom);

    assign bif.bus_din = use_rand ? rand_din : rf_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic              err;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        int                cyc;
    } exp_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] dout;
        logic              oe;
        int                cyc;
    } bus_ev_t;

    exp_t    sb[$];
    bus_ev_t rd_log[$];
    bus_ev_t wr_log[$];

    int   n_cmp = 0;
    int   n_fail = 0;
    int   last_acc = 0;
    logic overlap_seen = 1'b0;
    logic oe_bad_seen = 1'b0;
    logic idle_bus_bad = 1'b0;

    // Stream table: fields change every cycle while req_valid stays high.
    logic [1:0]        s_op    [15] = '{2'b01, 2'b01, 2'b11, 2'b00, 2'b01, 2'b11, 2'b10, 2'b11,
                                        2'b01, 2'b10, 2'b01, 2'b11, 2'b00, 2'b01, 2'b00};
    logic [3:0]        s_a     [15] = '{4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0, 4'd9, 4'd5,
                                        4'd5, 4'd5, 4'd3, 4'd0, 4'd0, 4'd5, 4'd0};
    logic [3:0]        s_b     [15] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd10, 4'd0,
                                        4'd0, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    logic [DATA_W-1:0] s_wd    [15] = '{14'h0123, 14'h3333, 14'h0, 14'h0, 14'h3FFF, 14'h0, 14'h0, 14'h0,
                                        14'h0000, 14'h0, 14'h0000, 14'h0, 14'h0, 14'h0001, 14'h0};

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic reportTimeout(input string name);
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    task automatic runMonitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bif.bus_rd && bif.bus_wr) overlap_seen = 1'b1;
            if (bif.bus_oe && !bif.bus_wr) oe_bad_seen = 1'b1;
            if (!bif.bus_rd && !bif.bus_wr && (bif.bus_addr != '0 || bif.bus_dout != '0))
                idle_bus_bad = 1'b1;
            if (bif.bus_rd) rd_log.push_back('{bif.bus_addr, bif.bus_dout, bif.bus_oe, cyc});
            if (bif.bus_wr) wr_log.push_back('{bif.bus_addr, bif.bus_dout, bif.bus_oe, cyc});
            if (bif.rsp_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("[TB] FAIL unexpected_rsp: rsp_valid=1 at cycle %0d, required no response", cyc);
                end else begin
                    e = sb.pop_front();
                    checkOutput("rsp_cycle", cyc, e.cyc);
                    checkOutput("rsp_err", bif.rsp_err, e.err);
                    checkOutput("rsp_data_a", bif.rsp_data_a, e.a);
                    checkOutput("rsp_data_b", bif.rsp_data_b, e.b);
                end
            end
        end
    endtask

    task automatic waitReady();
        int waited = 0;
        @(negedge clk);
        while (!bif.req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bif.req_ready) reportTimeout("req_ready_wait");
    endtask

    // lat is the spec cycle number of rsp_valid (accept edge = 0, cycle 1 follows it).
    task automatic applyStimulus(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                                 input logic [DATA_W-1:0] wd, input logic e_err,
                                 input logic [DATA_W-1:0] e_a, input logic [DATA_W-1:0] e_b,
                                 input int lat);
        waitReady();
        bif.req_op     = op;
        bif.req_addr_a = a;
        bif.req_addr_b = b;
        bif.req_wdata  = wd;
        bif.req_valid  = 1'b1;
        last_acc = cyc + 1;
        sb.push_back('{e_err, e_a, e_b, last_acc + lat - 1});
        @(negedge clk);
        bif.req_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int waited = 0;
        while (sb.size() != 0 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (sb.size() != 0) begin
            reportTimeout("rsp_wait");
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic clearLogs();
        rd_log.delete();
        wr_log.delete();
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_req_ready"}, bif.req_ready, 1);
        checkOutput({tag, "_rsp_valid"}, bif.rsp_valid, 0);
        checkOutput({tag, "_rsp_err"}, bif.rsp_err, 0);
        checkOutput({tag, "_bus_addr"}, bif.bus_addr, 0);
        checkOutput({tag, "_bus_rd"}, bif.bus_rd, 0);
        checkOutput({tag, "_bus_wr"}, bif.bus_wr, 0);
        checkOutput({tag, "_bus_dout"}, bif.bus_dout, 0);
        checkOutput({tag, "_bus_oe"}, bif.bus_oe, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int e0;
        fork
            runMonitor();
        join_none

        use_rand       = 1'b1;
        bif.req_valid  = 1'b0;
        bif.req_op     = 2'b00;
        bif.req_addr_a = 4'd0;
        bif.req_addr_b = 4'd0;
        bif.req_wdata  = '0;

        $display("[TB] reset with random bus_din");
        repeat (3) @(negedge clk);
        checkIdleOutputs("rst");
        checkOutput("rst_rsp_data_a", bif.rsp_data_a, 0);
        checkOutput("rst_rsp_data_b", bif.rsp_data_b, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkIdleOutputs("post_rst");
        use_rand = 1'b0;

        $display("[TB] write reg3 then read it back");
        clearLogs();
        applyStimulus(2'b01, 4'd3, 4'd0, 14'h1ABC, 1'b0, 14'h0000, 14'h0000, 2);
        waitDrain();
        checkOutput("wr_strobe_count", wr_log.size(), 1);
        checkOutput("wr_rd_strobe_count", rd_log.size(), 0);
        if (wr_log.size() > 0) begin
            checkOutput("wr_addr", wr_log[0].addr, 3);
            checkOutput("wr_dout", wr_log[0].dout, 14'h1ABC);
            checkOutput("wr_oe", wr_log[0].oe, 1);
            checkOutput("wr_cycle", wr_log[0].cyc, last_acc);
        end
        clearLogs();
        applyStimulus(2'b00, 4'd3, 4'd0, 14'h0, 1'b0, 14'h1ABC, 14'h0000, 3);
        waitDrain();
        checkOutput("rd_strobe_count", rd_log.size(), 1);
        if (rd_log.size() > 0) checkOutput("rd_addr", rd_log[0].addr, 3);

        $display("[TB] preload AX, FLAGS, AX7 and read pairs");
        applyStimulus(2'b01, 4'd0,  4'd0, 14'h0005, 1'b0, 14'h1ABC, 14'h0000, 2);
        applyStimulus(2'b01, 4'd8,  4'd0, 14'h3FFF, 1'b0, 14'h1ABC, 14'h0000, 2);
        applyStimulus(2'b01, 4'd15, 4'd0, 14'h2222, 1'b0, 14'h1ABC, 14'h0000, 2);
        waitDrain();
        clearLogs();
        applyStimulus(2'b10, 4'd0, 4'd8, 14'h0, 1'b0, 14'h0005, 14'h3FFF, 4);
        waitDrain();
        checkOutput("pair_strobe_count", rd_log.size(), 2);
        if (rd_log.size() == 2) begin
            checkOutput("pair_addr_first", rd_log[0].addr, 0);
            checkOutput("pair_addr_second", rd_log[1].addr, 8);
            checkOutput("pair_first_cycle", rd_log[0].cyc, last_acc);
            checkOutput("pair_second_cycle", rd_log[1].cyc, last_acc + 1);
        end
        applyStimulus(2'b10, 4'd15, 4'd15, 14'h0, 1'b0, 14'h2222, 14'h2222, 4);
        waitDrain();

        $display("[TB] illegal op");
        clearLogs();
        applyStimulus(2'b11, 4'd3, 4'd8, 14'h1111, 1'b1, 14'h2222, 14'h2222, 1);
        waitDrain();
        checkOutput("illegal_rd_strobes", rd_log.size(), 0);
        checkOutput("illegal_wr_strobes", wr_log.size(), 0);

        $display("[TB] req_valid held high with changing fields");
        waitReady();
        e0 = cyc + 1;
        sb.push_back('{1'b0, 14'h2222, 14'h2222, e0 + 1});
        sb.push_back('{1'b0, 14'h0123, 14'h2222, e0 + 5});
        sb.push_back('{1'b1, 14'h0123, 14'h2222, e0 + 7});
        sb.push_back('{1'b0, 14'h0123, 14'h1ABC, e0 + 12});
        for (int t = 0; t < 15; t++) begin
            if (t > 0) @(negedge clk);
            bif.req_op     = s_op[t];
            bif.req_addr_a = s_a[t];
            bif.req_addr_b = s_b[t];
            bif.req_wdata  = s_wd[t];
            bif.req_valid  = (t < 14);
        end
        waitDrain();

        $display("[TB] reset during RD_B");
        clearLogs();
        waitReady();
        bif.req_op     = 2'b10;
        bif.req_addr_a = 4'd5;
        bif.req_addr_b = 4'd3;
        bif.req_valid  = 1'b1;
        @(negedge clk);
        bif.req_valid = 1'b0;
        @(negedge clk);
        checkOutput("abort_rdb_strobe", bif.bus_rd, 1);
        checkOutput("abort_rdb_addr", bif.bus_addr, 3);
        rst = 1'b1;
        #1;
        checkOutput("abort_bus_rd_dropped", bif.bus_rd, 0);
        checkOutput("abort_rsp_data_a", bif.rsp_data_a, 0);
        checkOutput("abort_rsp_data_b", bif.rsp_data_b, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        checkIdleOutputs("abort_idle");

        checkOutput("rd_wr_overlap", overlap_seen, 0);
        checkOutput("oe_outside_wr", oe_bad_seen, 0);
        checkOutput("bus_nonzero_idle", idle_bus_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
